// File: rtl/int_ctrl.sv
// int_ctrl: prioritised, nesting interrupt controller driving a registered hwint/ack/eoi handshake
// with per-channel vectors and a word-wide configuration port.
module int_ctrl #(
    parameter int          NUM_IRQ    = 8,
    parameter int          PRIO_W     = 2,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'd4,
    localparam int         ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic               i_cfg_wr,
    input  logic [2:0]         i_cfg_addr,
    input  logic [31:0]        i_cfg_wdata,
    output logic [31:0]        o_cfg_rdata,
    output logic               o_hwint,
    output logic [ID_W-1:0]    o_int_id,
    output logic [31:0]        o_int_vec,
    input  logic               i_int_ack,
    input  logic               i_eoi,
    output logic               o_err
);
    typedef enum logic {IDLE, REQ} state_t;
    localparam int DEPTH = 2 ** PRIO_W;
    localparam int DW    = PRIO_W + 1;

    state_t             r_state;
    logic [NUM_IRQ-1:0] r_s1, r_s2, r_s3, r_pend, r_en, r_trig;
    logic [31:0]        r_prio;
    logic [PRIO_W-1:0]  r_stk [DEPTH];
    logic [DW-1:0]      r_depth;
    logic [PRIO_W-1:0]  w_prio [NUM_IRQ];
    logic [NUM_IRQ-1:0] w_wr_clr, w_wr_set, w_ack_clr, w_pend_nxt, w_cand;
    logic [PRIO_W-1:0]  w_top, w_cur, w_wprio;
    logic [ID_W-1:0]    w_win;
    logic [31:0]        w_vec, w_rdata;
    logic               w_any, w_push, w_pop;

    genvar g;
    generate
        for (g = 0; g < NUM_IRQ; g++) begin : g_prio
            if ((g + 1) * PRIO_W <= 32) begin : g_cfg
                assign w_prio[g] = r_prio[g*PRIO_W +: PRIO_W];
            end else begin : g_fixed
                assign w_prio[g] = '0;
            end
        end
    endgenerate

    assign w_wr_clr  = (i_cfg_wr && i_cfg_addr == 3'd3) ? i_cfg_wdata[NUM_IRQ-1:0] : '0;
    assign w_wr_set  = (i_cfg_wr && i_cfg_addr == 3'd4) ? i_cfg_wdata[NUM_IRQ-1:0] : '0;
    assign w_push    = (r_state == REQ) && i_int_ack;
    assign w_pop     = i_eoi && (r_depth != '0);
    assign w_ack_clr = w_push ? (NUM_IRQ'(1) << o_int_id) : '0;
    // Edge sets are applied after clears so a same-cycle edge always survives a W1C or ack
    assign w_pend_nxt = (r_trig & ((r_pend & ~(w_wr_clr | w_ack_clr)) | (r_s2 & ~r_s3) | w_wr_set))
                      | (~r_trig & r_s2);
    assign w_top = r_stk[PRIO_W'(r_depth - 1'b1)];
    assign w_cur = (r_depth != '0) ? w_top : '0;
    assign w_vec = VEC_BASE + 32'(w_win) * VEC_STRIDE;

    always_comb begin
        w_cand  = '0;
        w_any   = 1'b0;
        w_win   = '0;
        w_wprio = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            w_cand[i] = w_pend_nxt[i] && r_en[i] && (r_depth == '0 || w_prio[i] > w_top);
            if (w_cand[i] && (!w_any || w_prio[i] >= w_wprio)) begin
                w_any   = 1'b1;
                w_win   = ID_W'(i);
                w_wprio = w_prio[i];
            end
        end
    end

    assign w_rdata = (i_cfg_addr == 3'd0) ? 32'(r_en)
                   : (i_cfg_addr == 3'd1) ? 32'(r_trig)
                   : (i_cfg_addr == 3'd2) ? r_prio
                   : (i_cfg_addr == 3'd3) ? 32'(r_pend)
                   : (i_cfg_addr == 3'd5) ? {o_err, 15'd0, 8'(r_depth), 8'(w_cur)}
                   : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_s3        <= '0;
            r_pend      <= '0;
            r_en        <= '0;
            r_trig      <= '0;
            r_prio      <= '0;
            o_cfg_rdata <= '0;
            o_err       <= 1'b0;
        end else begin
            r_s1        <= i_irq;
            r_s2        <= r_s1;
            r_s3        <= r_s2;
            r_pend      <= w_pend_nxt;
            o_cfg_rdata <= w_rdata;
            o_err       <= (o_err && !(i_cfg_wr && i_cfg_addr == 3'd5 && i_cfg_wdata[31]))
                         || (i_eoi && r_depth == '0);
            if (i_cfg_wr && i_cfg_addr == 3'd0) r_en <= i_cfg_wdata[NUM_IRQ-1:0];
            if (i_cfg_wr && i_cfg_addr == 3'd1) r_trig <= i_cfg_wdata[NUM_IRQ-1:0];
            if (i_cfg_wr && i_cfg_addr == 3'd2) r_prio <= i_cfg_wdata;
        end
    end

    // Pop happens before push, so ack+eoi together replaces the top entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_depth <= '0;
            for (int i = 0; i < DEPTH; i++) r_stk[i] <= '0;
        end else begin
            r_depth <= r_depth - DW'(w_pop) + DW'(w_push);
            if (w_push) r_stk[PRIO_W'(r_depth - DW'(w_pop))] <= w_prio[o_int_id];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            o_hwint   <= 1'b0;
            o_int_id  <= '0;
            o_int_vec <= VEC_BASE;
        end else if (r_state == IDLE) begin
            if (w_any) begin
                r_state   <= REQ;
                o_hwint   <= 1'b1;
                o_int_id  <= w_win;
                o_int_vec <= w_vec;
            end
        end else if (i_int_ack || !w_cand[o_int_id]) begin
            r_state <= IDLE;
            o_hwint <= 1'b0;
        end else if (w_wprio > w_prio[o_int_id]) begin
            o_int_id  <= w_win;
            o_int_vec <= w_vec;
        end
    end
endmodule
